// File: rtl/scroll_pkg.sv
// Shared defaults, index-range helper and repeat FSM state encoding for the
// scroll window control stage.
package scroll_pkg;

    localparam int TEXT_W_DEF      = 128;
    localparam int WIN_NIBBLES_DEF = 4;

    // Per-direction button repeat state.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Largest leftmost-nibble index that still keeps the whole window inside the text.
    function automatic int calc_max_idx(input int text_w, input int win_nibbles);
        return text_w / 4 - win_nibbles;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer. The debounced
// level flips only after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronizer shift and stable-run counter next-state.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/scroll_window_ctrl.sv
// Scroll window control: debounced left/right buttons drive single steps and
// hold-to-repeat auto-scroll of a saturating nibble index into a captured text
// word; the selected window is registered for the digit-scan driver.
// Handshake: text_load is a one-cycle strobe with no ready; a load always wins
// over home and step in the same cycle.
module scroll_window_ctrl
    import scroll_pkg::*;
#(
    parameter  int TEXT_W              = TEXT_W_DEF,
    parameter  int WIN_NIBBLES         = WIN_NIBBLES_DEF,
    parameter  int DEBOUNCE_CYCLES     = 1_000_000,
    parameter  int REPEAT_DELAY_CYCLES = 50_000_000,
    parameter  int REPEAT_RATE_CYCLES  = 10_000_000,
    localparam int MAX_IDX             = calc_max_idx(TEXT_W, WIN_NIBBLES),
    localparam int IDX_W               = $clog2(MAX_IDX + 1),
    localparam int WIN_W               = 4 * WIN_NIBBLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic [TEXT_W-1:0] text_in,
    input  logic              text_load,
    output logic [IDX_W-1:0]  window_idx,
    output logic [WIN_W-1:0]  window_out,
    output logic              at_left,
    output logic              at_right
);

    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(MAX_IDX);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       db;
    logic             both, home, suppress;
    logic [1:0]       step;
    rpt_state_e       state_q [2];
    rpt_state_e       state_d [2];
    logic [RPT_W-1:0] cnt_q   [2];
    logic [RPT_W-1:0] cnt_d   [2];
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TEXT_W-1:0] text_q, text_d;
    logic [WIN_W-1:0] window_q, window_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .rst(rst), .btn_raw(btn_l), .btn_db(db[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .rst(rst), .btn_raw(btn_r), .btn_db(db[1])
    );

    // Both-pressed lockout and the two repeat FSMs' next state and step pulses.
    always_comb begin
        both     = db[0] & db[1];
        home     = both & ~lock_q;
        suppress = both | lock_q;
        lock_d   = lock_q;
        if (both)
            lock_d = 1'b1;
        else if (db == 2'b00)
            lock_d = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = '0;
        for (int d = 0; d < 2; d++) begin
            if (!db[d] || suppress) begin
                state_d[d] = RPT_IDLE;
                cnt_d[d]   = '0;
            end else begin
                case (state_q[d])
                    RPT_IDLE: begin
                        step[d]    = 1'b1;
                        state_d[d] = RPT_DELAY;
                        cnt_d[d]   = '0;
                    end
                    RPT_DELAY: begin
                        if (cnt_q[d] == DLY_LAST) begin
                            step[d]    = 1'b1;
                            state_d[d] = RPT_REPEAT;
                            cnt_d[d]   = '0;
                        end else begin
                            cnt_d[d] = cnt_q[d] + RPT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt_q[d] == RATE_LAST) begin
                            step[d]  = 1'b1;
                            cnt_d[d] = '0;
                        end else begin
                            cnt_d[d] = cnt_q[d] + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_d[d] = RPT_IDLE;
                        cnt_d[d]   = '0;
                    end
                endcase
            end
        end
    end

    // Index update (load > home > step, saturating) and window selection.
    always_comb begin
        idx_d = idx_q;
        if (text_load || home)
            idx_d = '0;
        else if (step[1] && idx_q != IDX_MAX)
            idx_d = idx_q + IDX_W'(1);
        else if (step[0] && idx_q != '0)
            idx_d = idx_q - IDX_W'(1);
        text_d   = text_load ? text_in : text_q;
        window_d = WIN_W'(text_q >> (4 * (MAX_IDX - int'(idx_q))));
    end

    // All control and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= RPT_IDLE;
            state_q[1] <= RPT_IDLE;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            lock_q     <= 1'b0;
            idx_q      <= '0;
            text_q     <= '0;
            window_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            idx_q    <= idx_d;
            text_q   <= text_d;
            window_q <= window_d;
        end
    end

    assign window_idx = idx_q;
    assign window_out = window_q;
    assign at_left    = (idx_q == '0);
    assign at_right   = (idx_q == IDX_MAX);

endmodule

// File: tb/tb_scroll_window_ctrl.sv
// Bench for scroll_window_ctrl: directed scenarios plus random button and load
// activity, checked every cycle against a behavioural reference model.
module tb_scroll_window_ctrl;

    localparam int DB   = 4;
    localparam int DLY  = 20;
    localparam int RATE = 5;
    localparam int MAXI = 28;
    localparam logic [127:0] TXT = 128'h0123456789ABCDEF_FEDCBA9876543210;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_l = 1'b0;
    logic         btn_r = 1'b0;
    logic         text_load = 1'b0;
    logic [127:0] text_in = '0;
    logic [4:0]   window_idx;
    logic [15:0]  window_out;
    logic         at_left;
    logic         at_right;

    always #5 clk = ~clk;

    scroll_window_ctrl #(
        .TEXT_W(128), .WIN_NIBBLES(4), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RATE)
    ) dut (
        .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r),
        .text_in(text_in), .text_load(text_load),
        .window_idx(window_idx), .window_out(window_out),
        .at_left(at_left), .at_right(at_right)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Buttons: 0 = left, 1 = right. m_hold counts cycles a direction has been
    // actively held (debounced, not locked out); -1 means not held.
    int           m_s1 [2];
    int           m_s2 [2];
    int           m_db [2];
    int           m_run [2];
    int           m_hold [2];
    bit           m_lock;
    int           m_idx;
    logic [127:0] m_text;
    logic [15:0]  m_win;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_s1[d] = 0; m_s2[d] = 0; m_db[d] = 0; m_run[d] = 0; m_hold[d] = -1;
        end
        m_lock = 0; m_idx = 0; m_text = '0; m_win = '0;
    endtask

    task automatic model_step();
        bit both, home, supp;
        bit stp [2];
        int btn [2];
        int h, nidx;
        logic [15:0] nwin;
        if (rst) begin
            model_reset();
            return;
        end
        btn[0] = int'(btn_l);
        btn[1] = int'(btn_r);
        both = (m_db[0] != 0) && (m_db[1] != 0);
        home = both && !m_lock;
        supp = both || m_lock;
        for (int d = 0; d < 2; d++) begin
            stp[d] = 0;
            if (m_db[d] == 0 || supp) begin
                m_hold[d] = -1;
            end else begin
                m_hold[d]++;
                h = m_hold[d];
                stp[d] = (h == 0) || (h == DLY) || (h > DLY && (h - DLY) % RATE == 0);
            end
        end
        if (both) m_lock = 1;
        else if (m_db[0] == 0 && m_db[1] == 0) m_lock = 0;
        nwin = 16'(m_text >> (4 * (MAXI - m_idx)));
        nidx = m_idx;
        if (text_load || home) nidx = 0;
        else if (stp[1]) nidx = (m_idx < MAXI) ? m_idx + 1 : MAXI;
        else if (stp[0]) nidx = (m_idx > 0) ? m_idx - 1 : 0;
        if (text_load) m_text = text_in;
        m_win = nwin;
        m_idx = nidx;
        for (int d = 0; d < 2; d++) begin
            if (m_s2[d] != m_db[d]) begin
                m_run[d]++;
                if (m_run[d] == DB) begin
                    m_db[d]  = m_s2[d];
                    m_run[d] = 0;
                end
            end else begin
                m_run[d] = 0;
            end
            m_s2[d] = m_s1[d];
            m_s1[d] = btn[d];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("idx", window_idx, m_idx);
        check_eq("window", window_out, m_win);
        check_eq("at_left", at_left, m_idx == 0);
        check_eq("at_right", at_right, m_idx == MAXI);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_text(input logic [127:0] t);
        text_in = t;
        text_load = 1'b1;
        tick();
        text_load = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        ticks(3);
        check_eq("rst_idx", window_idx, 0);
        check_eq("rst_window", window_out, 0);
        check_eq("rst_at_left", at_left, 1);
        check_eq("rst_at_right", at_right, 0);
        rst = 1'b0;
        tick();

        // Load and first window.
        load_text(TXT);
        check_eq("load_idx", window_idx, 0);
        tick();
        check_eq("load_window", window_out, 16'h0123);
        check_eq("load_at_left", at_left, 1);

        // Bounces shorter than the debounce time must be ignored.
        for (int k = 0; k < 5; k++) begin
            btn_r = 1'b1; ticks(3);
            btn_r = 1'b0; ticks(3);
        end
        ticks(6);
        check_eq("bounce_idx", window_idx, 0);

        // A short clean press gives exactly one step.
        btn_r = 1'b1; ticks(10);
        btn_r = 1'b0; ticks(12);
        check_eq("single_idx", window_idx, 1);
        check_eq("single_window", window_out, 16'h1234);

        // Hold right from 0 to saturation.
        load_text(TXT);
        btn_r = 1'b1; ticks(200);
        check_eq("sat_idx", window_idx, MAXI);
        check_eq("sat_window", window_out, 16'h3210);
        check_eq("sat_at_right", at_right, 1);
        btn_r = 1'b0; ticks(10);

        // Hold left back down to 0.
        btn_l = 1'b1; ticks(200);
        check_eq("left_idx", window_idx, 0);
        check_eq("left_at_left", at_left, 1);
        btn_l = 1'b0; ticks(10);

        // Both-pressed homing and lockout.
        btn_r = 1'b1;
        for (int i = 0; i < 200 && m_idx != 10; i++) tick();
        check_eq("reach_idx10", window_idx, 10);
        btn_l = 1'b1; ticks(30);
        check_eq("both_home", window_idx, 0);
        btn_l = 1'b0; ticks(40);
        check_eq("lock_hold", window_idx, 0);
        btn_r = 1'b0; ticks(12);
        check_eq("lock_release", window_idx, 0);
        btn_r = 1'b1; ticks(10);
        check_eq("rearm_idx", window_idx, 1);
        btn_r = 1'b0; ticks(10);

        // Reset while a button is held mid-delay.
        btn_r = 1'b1; ticks(15);
        rst = 1'b1; ticks(2);
        check_eq("midrst_idx", window_idx, 0);
        check_eq("midrst_window", window_out, 0);
        rst = 1'b0; ticks(12);
        check_eq("postrst_idx", window_idx, 1);
        btn_r = 1'b0; ticks(10);

        // Load held across a step: load wins.
        text_in = TXT;
        text_load = 1'b1;
        btn_r = 1'b1; ticks(12);
        check_eq("load_vs_step", window_idx, 0);
        text_load = 1'b0;
        btn_r = 1'b0; ticks(10);
        check_eq("load_vs_step_win", window_out, 16'h0123);

        // Random activity.
        for (int seg = 0; seg < 150; seg++) begin
            int dur;
            logic [1:0] b;
            b = 2'($urandom_range(0, 3));
            btn_l = b[0];
            btn_r = b[1];
            dur = $urandom_range(1, 40);
            for (int c = 0; c < dur; c++) begin
                if ($urandom_range(0, 29) == 0) begin
                    text_in = {$urandom(), $urandom(), $urandom(), $urandom()};
                    text_load = 1'b1;
                end
                if ($urandom_range(0, 399) == 0) rst = 1'b1;
                tick();
                text_load = 1'b0;
                rst = 1'b0;
            end
        end
        btn_l = 1'b0;
        btn_r = 1'b0;
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
